// File: rtl/uplink_rr_arbiter_pkg.sv
// Shared types for the uplink round-robin arbiter: FSM state encoding,
// requester id type, default flit width and the round-robin pick helper.
package uplink_rr_arbiter_pkg;

  localparam int FLIT_W_DEFAULT = 20;

  typedef logic [1:0] req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // First valid requester at or after ptr, wrapping modulo 4.
  function automatic req_id_t rr_pick(input logic [3:0] vld, input req_id_t ptr);
    req_id_t pick;
    req_id_t idx;
    logic    found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + req_id_t'(i);
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uplink_tag_fifo.sv
// DEPTH x 2-bit tag FIFO remembering which requester owns each flit in
// flight at the hub. The caller guarantees no push when full and no pop
// when empty; simultaneous push/pop leaves count unchanged.
module uplink_tag_fifo
  import uplink_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head_id,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  req_id_t         mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  // Tag storage write on push.
  // NOTE: the storage array has no reset; entries are only read once count
  // says they were written, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_id;
  end

  // Pointer and occupancy tracking; AW-bit pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_id = mem[head];

endmodule

// File: rtl/uplink_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a credit-controlled hub input.
// Flits are forwarded one cycle after acceptance; each hub credit is routed
// back to the requester whose flit is oldest in flight.
// Optional feature: define UPLINK_ARB_STATS_EN to add per-requester
// saturating grant counters gnt_cnt0..gnt_cnt3.
module uplink_rr_arbiter
  import uplink_rr_arbiter_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int FLIT_W = FLIT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arb_en,
  input  logic [FLIT_W-1:0]       req_data0,
  input  logic [FLIT_W-1:0]       req_data1,
  input  logic [FLIT_W-1:0]       req_data2,
  input  logic [FLIT_W-1:0]       req_data3,
  input  logic                    req_vld0,
  input  logic                    req_vld1,
  input  logic                    req_vld2,
  input  logic                    req_vld3,
  output logic                    req_rdy0,
  output logic                    req_rdy1,
  output logic                    req_rdy2,
  output logic                    req_rdy3,
  output logic                    req_cred0,
  output logic                    req_cred1,
  output logic                    req_cred2,
  output logic                    req_cred3,
  output logic [FLIT_W-1:0]       up_data,
  output logic                    up_vld,
  input  logic                    up_co,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic [1:0]              state_o,
  output logic                    err_uflow
`ifdef UPLINK_ARB_STATS_EN
  ,
  output logic [15:0]             gnt_cnt0,
  output logic [15:0]             gnt_cnt1,
  output logic [15:0]             gnt_cnt2,
  output logic [15:0]             gnt_cnt3
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  arb_state_e         state;
  arb_state_e         state_nxt;
  req_id_t            rr_ptr;
  req_id_t            grant;
  req_id_t            head_id;
  logic [3:0]         vld;
  logic [3:0]         cred;
  logic [FLIT_W-1:0]  data_arr [4];
  logic               accept;
  logic               pop;

  assign vld         = {req_vld3, req_vld2, req_vld1, req_vld0};
  assign data_arr[0] = req_data0;
  assign data_arr[1] = req_data1;
  assign data_arr[2] = req_data2;
  assign data_arr[3] = req_data3;

  assign grant  = rr_pick(vld, rr_ptr);
  assign accept = (state == ST_RUN) && (|vld) && (outstanding < CW'(DEPTH));
  // An underflowing credit is dropped here so the FIFO never pops empty.
  assign pop    = up_co && (outstanding != '0);

  assign req_rdy0 = accept && (grant == 2'd0);
  assign req_rdy1 = accept && (grant == 2'd1);
  assign req_rdy2 = accept && (grant == 2'd2);
  assign req_rdy3 = accept && (grant == 2'd3);

  assign {req_cred3, req_cred2, req_cred1, req_cred0} = cred;
  assign state_o = state;

  uplink_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .count   (outstanding)
  );

  // Next-state logic for the enable/drain FSM.
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; any path that skipped state_nxt would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arb_en) state_nxt = ST_RUN;
      ST_RUN:   if (!arb_en) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (arb_en)                 state_nxt = ST_RUN;
        else if (outstanding == '0) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and round-robin pointer; the pointer moves only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (accept) rr_ptr <= grant + 2'd1;
    end
  end

  // Registered flit path to the hub; data holds between flits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_vld  <= 1'b0;
      up_data <= '0;
    end else begin
      up_vld <= accept;
      if (accept) up_data <= data_arr[grant];
    end
  end

  // Credit return to the owner of the oldest in-flight tag, plus sticky
  // underflow flag for credits arriving with nothing outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cred      <= '0;
      err_uflow <= 1'b0;
    end else begin
      cred <= pop ? (4'b0001 << head_id) : 4'b0000;
      if (up_co && (outstanding == '0)) err_uflow <= 1'b1;
    end
  end

`ifdef UPLINK_ARB_STATS_EN
  logic [15:0] gnt_cnt [4];

  // Saturating per-requester accept counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) gnt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (grant == req_id_t'(i)) && (gnt_cnt[i] != 16'hFFFF))
          gnt_cnt[i] <= gnt_cnt[i] + 16'd1;
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt[0];
  assign gnt_cnt1 = gnt_cnt[1];
  assign gnt_cnt2 = gnt_cnt[2];
  assign gnt_cnt3 = gnt_cnt[3];
`endif

endmodule

// File: tb/tb_uplink_rr_arbiter.sv
// Self-checking bench for uplink_rr_arbiter: a queue-based behavioural model
// is compared against every DUT output on every cycle, with directed
// scenarios pinned by literal expectations and a randomized phase.
module tb_uplink_rr_arbiter;

  localparam int DEPTH  = 8;
  localparam int FLIT_W = 20;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arb_en = 1'b0;
  logic [FLIT_W-1:0] d [4];
  logic [3:0]        v = 4'b0;
  logic              co = 1'b0;

  wire  [3:0]        rdy;
  wire  [3:0]        cred;
  wire  [FLIT_W-1:0] up_data;
  wire               up_vld;
  wire  [CW-1:0]     outstanding;
  wire  [1:0]        state_o;
  wire               err_uflow;

  always #5 clk = ~clk;

  uplink_rr_arbiter #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .req_data0   (d[0]),
    .req_data1   (d[1]),
    .req_data2   (d[2]),
    .req_data3   (d[3]),
    .req_vld0    (v[0]),
    .req_vld1    (v[1]),
    .req_vld2    (v[2]),
    .req_vld3    (v[3]),
    .req_rdy0    (rdy[0]),
    .req_rdy1    (rdy[1]),
    .req_rdy2    (rdy[2]),
    .req_rdy3    (rdy[3]),
    .req_cred0   (cred[0]),
    .req_cred1   (cred[1]),
    .req_cred2   (cred[2]),
    .req_cred3   (cred[3]),
    .up_data     (up_data),
    .up_vld      (up_vld),
    .up_co       (co),
    .outstanding (outstanding),
    .state_o     (state_o),
    .err_uflow   (err_uflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: state as 0/1/2, tags in flight as a queue.
  int                m_state;
  int                m_rr;
  int                tagq[$];
  logic              m_up_vld;
  logic [FLIT_W-1:0] m_up_data;
  logic [3:0]        m_cred;
  logic              m_err;
  int                glog[$];
  logic [3:0]        last_rdy;
  int                cred_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_rr      = 0;
    tagq.delete();
    m_up_vld  = 1'b0;
    m_up_data = '0;
    m_cred    = 4'b0;
    m_err     = 1'b0;
  endtask

  function automatic int model_grant(input logic [3:0] vv);
    for (int i = 0; i < 4; i++)
      if (vv[(m_rr + i) % 4]) return (m_rr + i) % 4;
    return -1;
  endfunction

  function automatic logic model_accept(input logic [3:0] vv);
    return (m_state == 1) && (vv != 4'b0) && (tagq.size() < DEPTH);
  endfunction

  task automatic model_tick(input logic e, input logic [3:0] vv, input logic c);
    int   out;
    int   g;
    logic acc;
    out = tagq.size();
    acc = model_accept(vv);
    g   = model_grant(vv);
    m_cred = 4'b0;
    if (c && out > 0) begin
      m_cred[tagq[0]] = 1'b1;
      void'(tagq.pop_front());
    end
    if (c && out == 0) m_err = 1'b1;
    if (acc) begin
      tagq.push_back(g);
      m_up_data = d[g];
      m_rr = (g + 1) % 4;
    end
    m_up_vld = acc;
    case (m_state)
      0: if (e) m_state = 1;
      1: if (!e) m_state = 2;
      default: if (e) m_state = 1; else if (out == 0) m_state = 0;
    endcase
  endtask

  // One cycle: drive at the falling edge, compare every output, update the
  // model on the rising edge, return at the next falling edge.
  task automatic step(input logic e, input logic [3:0] vv, input logic c);
    logic       acc;
    logic [3:0] exp_rdy;
    arb_en = e;
    v      = vv;
    co     = c;
    for (int i = 0; i < 4; i++) d[i] = FLIT_W'($urandom);
    #1;
    acc     = model_accept(vv);
    exp_rdy = acc ? (4'b0001 << model_grant(vv)) : 4'b0000;
    check("rdy",         32'(rdy),         32'(exp_rdy));
    check("up_vld",      32'(up_vld),      32'(m_up_vld));
    check("up_data",     32'(up_data),     32'(m_up_data));
    check("cred",        32'(cred),        32'(m_cred));
    check("outstanding", 32'(outstanding), 32'(tagq.size()));
    check("state",       32'(state_o),     32'(m_state));
    check("err_uflow",   32'(err_uflow),   32'(m_err));
    last_rdy = rdy;
    if (acc) glog.push_back(model_grant(vv));
    @(posedge clk);
    model_tick(e, vv, c);
    @(negedge clk);
    cred_seen += $countones(cred);
  endtask

  function automatic logic has_out();
    return tagq.size() > 0;
  endfunction

  initial begin
    int exp_seq[5];
    int n0;
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) d[i] = '0;
    cred_seen = 0;
    model_reset();

    // Reset values.
    #12;
    check("rst_state",       32'(state_o),     32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_up_vld",      32'(up_vld),      32'd0);
    check("rst_up_data",     32'(up_data),     32'd0);
    check("rst_cred",        32'(cred),        32'd0);
    check("rst_err",         32'(err_uflow),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b0);

    // All four requesting, hub consuming steadily: strict rotation.
    step(1'b1, 4'h0, 1'b0);
    glog.delete();
    for (int k = 0; k < 5; k++) step(1'b1, 4'hF, has_out());
    check("rot_count", 32'(glog.size()), 32'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      check("rot_grant", 32'(glog[k]), 32'(exp_seq[k]));
    for (int k = 0; k < 20 && m_state != 0; k++) step(1'b0, 4'h0, has_out());
    check("rot_idle", 32'(state_o), 32'd0);
    check("rot_err",  32'(err_uflow), 32'd0);

    // Single requester fills the hub; one credit admits exactly one more.
    step(1'b1, 4'h0, 1'b0);
    n0 = glog.size();
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0100, 1'b0);
    check("full_outstanding", 32'(outstanding), 32'd8);
    step(1'b1, 4'b0100, 1'b0);
    check("full_rdy2", 32'(last_rdy[2]), 32'd0);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    check("full_accepts", 32'(glog.size() - n0), 32'd9);
    check("full_again",   32'(outstanding), 32'd8);

    // Accept and credit together at 5 outstanding.
    for (int k = 0; k < 3; k++) step(1'b1, 4'h0, 1'b1);
    step(1'b1, 4'b0001, 1'b1);
    check("same_outstanding", 32'(outstanding), 32'd5);
    check("same_cred_oldest", 32'(cred), 32'b0100);

    // Drop enable with 3 outstanding: drain, no grants, 3 credits, idle.
    step(1'b1, 4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b1);
    check("drain_start", 32'(outstanding), 32'd3);
    step(1'b0, 4'h0, 1'b0);
    check("drain_state", 32'(state_o), 32'd2);
    n0 = glog.size();
    cred_seen = 0;
    for (int k = 0; k < 20 && m_state != 0; k++) step(1'b0, 4'hF, has_out());
    check("drain_grants", 32'(glog.size() - n0), 32'd0);
    check("drain_creds",  32'(cred_seen), 32'd3);
    check("drain_idle",   32'(state_o), 32'd0);

    // Credit with nothing outstanding: no pulse, sticky error.
    step(1'b0, 4'h0, 1'b1);
    check("uflow_err",  32'(err_uflow), 32'd1);
    check("uflow_cred", 32'(cred), 32'd0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    check("uflow_sticky", 32'(err_uflow), 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 9) != 0), 4'($urandom), ($urandom_range(0, 99) < 45));

    // Reset with 4 outstanding discards the tags.
    for (int k = 0; k < 20 && has_out(); k++) step(1'b1, 4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 4'($urandom_range(1, 15)), 1'b0);
    check("pre_rst_outstanding", 32'(outstanding), 32'd4);
    arb_en = 1'b0;
    v      = 4'b0;
    co     = 1'b0;
    rst    = 1'b0;
    #2;
    model_reset();
    check("mid_rst_state",       32'(state_o),     32'd0);
    check("mid_rst_outstanding", 32'(outstanding), 32'd0);
    check("mid_rst_up_vld",      32'(up_vld),      32'd0);
    check("mid_rst_up_data",     32'(up_data),     32'd0);
    check("mid_rst_cred",        32'(cred),        32'd0);
    check("mid_rst_err",         32'(err_uflow),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    cred_seen = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    check("post_rst_creds", 32'(cred_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uplink_rr_arbiter.md
UPLINK_RR_ARBITER -- requirements
Module: uplink_rr_arbiter

Interface
REQ-001 Parameter DEPTH, default 8: maximum flits outstanding at the hub; power of two, 2..16.
REQ-002 Parameter FLIT_W, default 20: flit width in bits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 arb_en  input  1  enable; low requests a drain and no new grants.
REQ-006 req_dataN (N=0..3)  input  FLIT_W  requester N flit.
REQ-007 req_vldN (N=0..3)  input  1  requester N flit valid.
REQ-008 req_rdyN (N=0..3)  output  1  combinational; flit N is taken this cycle.
REQ-009 req_credN (N=0..3)  output  1  registered one-cycle credit pulse back to requester N.
REQ-010 up_data  output  FLIT_W  registered flit to hub input.
REQ-011 up_vld  output  1  registered one-cycle flit valid to hub.
REQ-012 up_co  input  1  hub credit-out pulse; one flit consumed by hub.
REQ-013 outstanding  output  $clog2(DEPTH)+1  flits sent and not yet credited.
REQ-014 state_o  output  2  current FSM state encoding.
REQ-015 err_uflow  output  1  sticky; up_co seen with outstanding==0.

Function
REQ-016 FSM states: IDLE(0), RUN(1), DRAIN(2). IDLE->RUN when arb_en=1. RUN->DRAIN when arb_en=0. DRAIN->IDLE when outstanding==0 and arb_en=0. DRAIN->RUN when arb_en=1.
REQ-017 accept = (state==RUN) && any req_vldN && outstanding<DEPTH.
REQ-018 Grant is round-robin: the first valid requester at or after rr_ptr, modulo 4. rr_ptr <= grant+1 on accept only.
REQ-019 req_rdyN = accept && grant==N; at most one rdy high per cycle.
REQ-020 On accept, up_data <= selected req_data and up_vld <= 1 next cycle (latency 1). Otherwise up_vld <= 0 and up_data holds.
REQ-021 On accept, the 2-bit grant id is pushed into a DEPTH-entry tag FIFO.
REQ-022 On up_co with outstanding>0, the FIFO head is popped and req_cred[head] pulses next cycle.
REQ-023 Accept and pop in the same cycle: outstanding unchanged; both pointers advance.
REQ-024 At outstanding==DEPTH (full): no accept; a pop in that cycle frees the slot for the following cycle only.
REQ-025 Pointers wrap modulo DEPTH with no bubble.
REQ-026 up_co with outstanding==0: ignored (no pop, no credit) and err_uflow <= 1.
REQ-027 Credit returns continue in IDLE and DRAIN.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, rr_ptr=0, head=tail=0, outstanding=0, up_vld=0, up_data=0, all req_cred=0, err_uflow=0.
REQ-029 Reset mid-operation discards in-flight tags; no credits are issued for them.

Configuration
REQ-030 Macro UPLINK_ARB_STATS_EN defined: adds outputs gnt_cntN (N=0..3, 16 bits), saturating counts of accepts per requester, reset to 0.
REQ-031 Macro undefined: the gnt_cntN ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Shared package holds the FSM state enum, FLIT_W default, and the 2-bit requester-id type.
REQ-033 Sub-module uplink_tag_fifo (DEPTH x 2 bit, push/pop, count) holds the tag FIFO; arbitration and FSM stay in the top module.

Verification
REQ-034 All four vld held high in RUN, up_co every cycle -> grants 0,1,2,3,0 in order, up_vld continuous, credits 2 cycles after each grant.
REQ-035 Only req 2 valid, no up_co for 8 accepts -> outstanding=8, rdy2 low on the 9th cycle; a single up_co -> exactly one more accept.
REQ-036 Accept and up_co in the same cycle at outstanding=5 -> outstanding stays 5, credit goes to the oldest tag.
REQ-037 arb_en dropped with 3 outstanding -> DRAIN, no grants, 3 credits returned, then IDLE.
REQ-038 up_co at outstanding=0 -> no credit pulse, err_uflow=1 until reset.
REQ-039 rst asserted with 4 outstanding, then released -> all outputs 0, state IDLE, no credits issued afterwards.
